reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Parametrised successor to the power-on reset synchroniser. Converts the board-level asynchronous active-low reset into NUM_CHANNELS active-high reset outputs, synchronised to i_clk. Each output asserts asynchronously and deasserts synchronously after a configurable hold time, with a staggered release order. It also accepts a synchronous soft-reset request that re-runs the release sequence. It sits at the top level and drives the per-subsystem resets (e.g. PLL-dependent logic, VGA timing, pattern generators).

Parameters:
SYNC_STAGES, 3, synchroniser flop count; legal range >= 2.
HOLD_CYCLES, 16, cycles reset stays asserted after the synchroniser output goes high; legal range >= 1.
NUM_CHANNELS, 3, number of reset outputs; legal range >= 1.
STAGGER_CYCLES, 4, cycles between release of consecutive channels; legal range >= 1.
SOFT_CYCLES, 8, cycles all channels stay asserted after a soft reset request; legal range >= 1.

Ports:
i_clk  input  1  system clock; all state changes on its rising edge.
i_asyncReset  input  1  asynchronous, active-low board reset.
i_softReset  input  1  synchronous, active-high soft-reset request; sampled only in RUN.
o_syncReset  output  NUM_CHANNELS  active-high reset per channel; bit 0 is released first.
o_resetDone  output  1  high once every channel is released.

Behaviour:
- Reset assertion:
  - i_asyncReset low asynchronously clears the synchroniser chain and the counter, and sets state to SYNC.
  - All o_syncReset bits go to 1 and o_resetDone goes to 0 immediately, with no clock required.
  - Any low pulse, including one shorter than a clock period, has this effect.
- Synchroniser: SYNC_STAGES flops in a chain; the first flop's data input is constant 1. The chain output is the last stage.
- Timing reference: edge n is the n-th rising edge of i_clk with i_asyncReset high, counting from 1.
- States (binary encoded, registered):
  - SYNC: wait until the chain output is 1 (edge SYNC_STAGES), then go to HOLD with the counter cleared.
  - HOLD: count HOLD_CYCLES edges, then go to RELEASE.
  - RELEASE: release channels in order k = 0..NUM_CHANNELS-1, spaced STAGGER_CYCLES apart. After the last channel is released, go to RUN.
  - RUN: steady state.
  - SOFT: count SOFT_CYCLES edges, then go to RELEASE.
- Required release timing after async reset:
  - o_syncReset[k] falls at edge SYNC_STAGES + HOLD_CYCLES + k*STAGGER_CYCLES.
  - o_resetDone rises at the same edge as the last channel falls.
  - With defaults: channel 0 at edge 19, channel 1 at edge 23, channel 2 at edge 27; done at edge 27.
- NUM_CHANNELS = 1: no stagger; done rises together with channel 0.
- Outputs come directly from flops, so there is no combinational glitching. A released channel stays low until the next async reset or soft reset.
- Soft reset:
  - i_softReset is ignored in SYNC, HOLD, RELEASE and SOFT.
  - If i_softReset is 1 at edge s in RUN: all o_syncReset bits go to 1 and o_resetDone to 0 at edge s, and state becomes SOFT.
  - o_syncReset[k] then falls at edge s + SOFT_CYCLES + k*STAGGER_CYCLES; o_resetDone rises with the last channel.
  - The synchroniser and hold phase are not re-run.
- If i_softReset is still high when RUN is re-entered, it retriggers on the next edge, giving back-to-back sequences.
- Async reset during any state (including SOFT or mid-RELEASE) aborts the sequence and restarts it from SYNC.
- Counter width: $clog2(max(HOLD_CYCLES, SOFT_CYCLES, STAGGER_CYCLES*(NUM_CHANNELS-1)) + 1). The counter saturates and never wraps.
- Unused or illegal states recover to SYNC on the next edge, with all outputs asserted.

Test Plan:
1. Defaults, i_asyncReset low for 5 cycles then high → o_syncReset = 3'b111 throughout reset; bit 0 falls at edge 19, bit 1 at 23, bit 2 at 27; o_resetDone rises at edge 27.
2. In RUN, drop i_asyncReset for 2 ns between clock edges → o_syncReset = 3'b111 and o_resetDone = 0 with no clock edge; full sequence re-runs (channel 0 released at edge 19).
3. In RUN, pulse i_softReset for 1 cycle at edge s → all outputs 1 at edge s; channels fall at s+8, s+12, s+16; done at s+16.
4. Assert i_softReset during HOLD and during RELEASE → no effect; release timing identical to scenario 1.
5. Async reset asserted mid-RELEASE (after channel 0 released, before channel 1) → all channels reassert immediately; sequence restarts from edge 1.
6. NUM_CHANNELS=1, SYNC_STAGES=2, HOLD_CYCLES=1 → o_syncReset falls and o_resetDone rises at edge 3; soft reset held high for 20 cycles → repeated 1-cycle-gap sequences of SOFT_CYCLES length.

Source files
------------

// File: rtl/reset_sequencer.sv
// Board reset synchroniser and staggered multi-channel reset release sequencer.
// Outputs assert asynchronously and release in bit order after a hold time or a soft-reset request.
`timescale 1ns/1ps

module reset_sequencer #(
    parameter int SYNC_STAGES    = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int NUM_CHANNELS   = 3,
    parameter int STAGGER_CYCLES = 4,
    parameter int SOFT_CYCLES    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_asyncReset,
    input  logic                    i_softReset,
    output logic [NUM_CHANNELS-1:0] o_syncReset,
    output logic                    o_resetDone
);

    localparam int STAG_SPAN = STAGGER_CYCLES * (NUM_CHANNELS - 1);
    localparam int MAX_HS    = (HOLD_CYCLES > SOFT_CYCLES) ? HOLD_CYCLES : SOFT_CYCLES;
    localparam int CNT_MAX   = (MAX_HS > STAG_SPAN) ? MAX_HS : STAG_SPAN;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

    localparam logic [NUM_CHANNELS-1:0] ALL_RST   = '1;
    localparam logic [NUM_CHANNELS-1:0] FIRST_REL = ALL_RST << 1;
    localparam logic [NUM_CHANNELS-1:0] LAST_CH   = NUM_CHANNELS'(1) << (NUM_CHANNELS - 1);
    localparam logic                    ONE_CH    = (NUM_CHANNELS == 1);
    localparam logic                    HOLD_ONE  = (HOLD_CYCLES == 1);

    typedef enum logic [2:0] {
        SYNC    = 3'd0,
        HOLD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        SOFT    = 3'd4
    } state_e;

    state_e                  state_q;
    logic [SYNC_STAGES-1:0]  chain_q;
    logic [SYNC_STAGES-1:0]  chain_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_CHANNELS-1:0] rst_q;
    logic                    done_q;
    logic                    start_rel;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    assign chain_d = {chain_q[SYNC_STAGES-2:0], 1'b1};

    // The edge that sees the chain output high is already the first hold edge.
    always_comb begin
        start_rel = 1'b0;
        case (state_q)
            SYNC:    start_rel = chain_q[SYNC_STAGES-1] && HOLD_ONE;
            HOLD:    start_rel = (cnt_q == HOLD_LAST);
            SOFT:    start_rel = (cnt_q == SOFT_LAST);
            default: start_rel = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_asyncReset) begin
        if (!i_asyncReset) begin
            chain_q <= '0;
            cnt_q   <= '0;
            state_q <= SYNC;
            rst_q   <= ALL_RST;
            done_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            if (start_rel) begin
                rst_q   <= FIRST_REL;
                cnt_q   <= '0;
                done_q  <= ONE_CH;
                state_q <= ONE_CH ? RUN : RELEASE;
            end else begin
                case (state_q)
                    SYNC: begin
                        if (chain_q[SYNC_STAGES-1]) begin
                            state_q <= HOLD;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    HOLD, SOFT: cnt_q <= sat_inc(cnt_q);
                    RELEASE: begin
                        if (cnt_q == STAG_LAST) begin
                            rst_q <= rst_q << 1;
                            cnt_q <= '0;
                            if (rst_q == LAST_CH) begin
                                done_q  <= 1'b1;
                                state_q <= RUN;
                            end
                        end else begin
                            cnt_q <= sat_inc(cnt_q);
                        end
                    end
                    RUN: begin
                        if (i_softReset) begin
                            rst_q   <= ALL_RST;
                            done_q  <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= SOFT;
                        end
                    end
                    default: begin
                        rst_q   <= ALL_RST;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= SYNC;
                    end
                endcase
            end
        end
    end

    assign o_syncReset = rst_q;
    assign o_resetDone = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a single-channel short instance, each
// checked by a monitor that pops expected output changes (edge number and value) from a queue.
`timescale 1ns/1ps

module tb_reset_sequencer;

    localparam int S_A = 3, H_A = 16, N_A = 3, ST_A = 4, SF_A = 8;
    localparam int S_B = 2, H_B = 1, N_B = 1, ST_B = 4, SF_B = 3;

    typedef struct {
        int       edge_n;
        logic [2:0] vec;
        logic     done;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arA = 1'b1, sfA = 1'b0, arB = 1'b1, sfB = 1'b0;
    logic [2:0] oA;
    logic       dA;
    logic [0:0] oB;
    logic       dB;

    int  cyc = 0;
    int  nchk = 0, nerr = 0;
    int  doneA = 0, doneB = 0, lastB = 0;
    bit  mon_en = 1'b0;
    ev_t qa[$];
    ev_t qb[$];

    logic [2:0] mA_vec = 3'b111;
    logic       mA_done = 1'b0;
    logic [3:0] prevA = 4'b1110;
    logic [1:0] prevB = 2'b10;

    reset_sequencer #(
        .SYNC_STAGES(S_A), .HOLD_CYCLES(H_A), .NUM_CHANNELS(N_A),
        .STAGGER_CYCLES(ST_A), .SOFT_CYCLES(SF_A)
    ) dut_a (
        .i_clk(clk), .i_asyncReset(arA), .i_softReset(sfA),
        .o_syncReset(oA), .o_resetDone(dA)
    );

    reset_sequencer #(
        .SYNC_STAGES(S_B), .HOLD_CYCLES(H_B), .NUM_CHANNELS(N_B),
        .STAGGER_CYCLES(ST_B), .SOFT_CYCLES(SF_B)
    ) dut_b (
        .i_clk(clk), .i_asyncReset(arB), .i_softReset(sfB),
        .o_syncReset(oB), .o_resetDone(dB)
    );

    always @(posedge clk) cyc++;

    function automatic void chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push_a(input int en, input logic [2:0] v, input logic d);
        ev_t e;
        e.edge_n = en; e.vec = v; e.done = d;
        qa.push_back(e);
    endfunction

    function automatic void push_b(input int en, input logic v, input logic d);
        ev_t e;
        e.edge_n = en; e.vec = {2'b00, v}; e.done = d;
        qb.push_back(e);
    endfunction

    // Channel k of a sequence starting at 'start' releases at start + gap + k*stagger.
    function automatic void sched_a(input int start, input int gap);
        logic [2:0] all_on;
        all_on = 3'b111;
        for (int k = 0; k < N_A; k++) begin
            push_a(start + gap + k * ST_A, all_on << (k + 1), (k == N_A - 1));
        end
        doneA = start + gap + (N_A - 1) * ST_A;
    endfunction

    always @(negedge clk) begin : mon_a
        ev_t        e;
        logic [3:0] cur;
        if (mon_en) begin
            if (qa.size() > 0 && qa[0].edge_n < cyc) begin
                nchk++; nerr++;
                $display("FAIL A missed: expected vec %b done %b at edge %0d, nothing seen by edge %0d",
                         qa[0].vec, qa[0].done, qa[0].edge_n, cyc);
                void'(qa.pop_front());
            end
            cur = {oA, dA};
            if (cur !== prevA) begin
                if (qa.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL A unexpected: got vec %b done %b at edge %0d, required no change", oA, dA, cyc);
                end else begin
                    e = qa.pop_front();
                    chk("A edge", cyc, e.edge_n);
                    chk("A vec", int'(oA), int'(e.vec));
                    chk("A done", int'(dA), int'(e.done));
                    mA_vec = e.vec; mA_done = e.done;
                end
                prevA = cur;
            end
        end
    end

    always @(negedge clk) begin : mon_b
        ev_t        e;
        logic [1:0] cur;
        if (mon_en) begin
            if (qb.size() > 0 && qb[0].edge_n < cyc) begin
                nchk++; nerr++;
                $display("FAIL B missed: expected rst %b done %b at edge %0d, nothing seen by edge %0d",
                         qb[0].vec[0], qb[0].done, qb[0].edge_n, cyc);
                void'(qb.pop_front());
            end
            cur = {oB, dB};
            if (cur !== prevB) begin
                if (qb.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL B unexpected: got rst %b done %b at edge %0d, required no change", oB, dB, cyc);
                end else begin
                    e = qb.pop_front();
                    chk("B edge", cyc, e.edge_n);
                    chk("B rst", int'(oB), int'(e.vec[0]));
                    chk("B done", int'(dB), int'(e.done));
                end
                prevB = cur;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Short low pulse between edges; edge 1 of the new sequence is the next rising edge.
    task automatic a_async_pulse();
        arA = 1'b0;
        #1;
        chk("A async assert rst", int'(oA), 7);
        chk("A async assert done", int'(dA), 0);
        qa.delete();
        if (mA_vec != 3'b111 || mA_done) push_a(cyc, 3'b111, 1'b0);
        #1;
        arA = 1'b1;
        sched_a(cyc, S_A + H_A);
    endtask

    task automatic a_soft_pulse();
        int s;
        sfA = 1'b1;
        s = cyc + 1;
        push_a(s, 3'b111, 1'b0);
        sched_a(s, SF_A);
        tick(1);
        sfA = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, r, s0, off;
        #1;
        arA = 1'b0;
        arB = 1'b0;
        #1;
        mon_en = 1'b1;
        tick(1);
        repeat (5 + int'($urandom_range(0, 3))) begin
            chk("A held rst", int'(oA), 7);
            chk("A held done", int'(dA), 0);
            chk("B held rst", int'(oB), 1);
            tick(1);
        end

        // Power-on release with default timing.
        arA = 1'b1;
        sched_a(cyc, S_A + H_A);
        wait_until(doneA + 2);

        // Single-cycle soft reset pulses in RUN.
        repeat (3) begin
            tick(int'($urandom_range(0, 5)));
            a_soft_pulse();
            wait_until(doneA + 1);
        end

        // Sub-cycle async pulse while running.
        tick(int'($urandom_range(1, 4)));
        a_async_pulse();
        wait_until(doneA + 2);

        // Soft requests during SYNC, HOLD and RELEASE must be ignored.
        a_async_pulse();
        while (cyc < doneA + 1) begin
            sfA = (cyc + 1 <= doneA) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick(1);
        end
        sfA = 1'b0;
        wait_until(doneA + 2);

        // Abort between channel 0 and channel 1 release.
        a_async_pulse();
        off = int'($urandom_range(1, ST_A - 1));
        wait_until(doneA - (N_A - 1) * ST_A + off);
        a_async_pulse();
        wait_until(doneA + 3);

        // Single-channel instance: release at edge 3, then soft held high for 20 edges.
        arB = 1'b1;
        doneB = cyc + S_B + H_B;
        push_b(doneB, 1'b0, 1'b1);
        wait_until(doneB + 1);
        sfB = 1'b1;
        s0 = cyc + 1;
        e = s0;
        r = doneB;
        while (e <= s0 + 19) begin
            push_b(e, 1'b1, 1'b0);
            r = e + SF_B + (N_B - 1) * ST_B;
            push_b(r, 1'b0, 1'b1);
            e = r + 1;
        end
        lastB = r;
        tick(20);
        sfB = 1'b0;
        wait_until(lastB + 3);

        chk("A queue drained", qa.size(), 0);
        chk("B queue drained", qb.size(), 0);
        chk("A final done", int'(dA), 1);
        chk("B final done", int'(dB), 1);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
